// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Contents: FSM state enum, transaction owner enum, beat count, byte helper.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam int BEATS = 4;

    // Select little-endian byte lane idx of a 32-bit word.
    function automatic logic [7:0] word_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter holding the last-grant flag.
// Ports: clk_i, rst_i (async high), req_i[1:0], en_i, gnt_o[1:0] one-hot.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // 1 = requester 1 (debug) was granted last, 0 = requester 0 (fetch)
    logic last_gnt_q;
    logic last_gnt_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                // Tie: favour whoever was not served last
                2'b11:   gnt_o = last_gnt_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (|gnt_o) begin
            last_gnt_d = gnt_o[1];
        end
    end

    // Reset to "debug last" so fetch wins the first tie
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a byte-wide instruction memory port between fetch and debug.
// Ports: Clk, Rst (async high); If* fetch side; Dbg* debug side; Mem* array; Busy.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          IfReq,
    input  logic [31:0]   IfAddr,
    output logic          IfValid,
    output logic [31:0]   IfData,
    input  logic          DbgReq,
    input  logic          DbgWe,
    input  logic [31:0]   DbgAddr,
    input  logic [31:0]   DbgWData,
    output logic          DbgValid,
    output logic [31:0]   DbgRData,
    output logic [AW-1:0] MemAddr,
    input  logic [7:0]    MemRdData,
    output logic          MemWe,
    output logic [7:0]    MemWrData,
    output logic          Busy
);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_data_q, if_data_d;
    logic [31:0]   dbg_data_q, dbg_data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wr_q, wr_d;
    logic [1:0]    gnt;
    logic [AW-1:0] beat_addr;

    // Upper address bits are deliberately ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IfAddr[31:AW], DbgAddr[31:AW]};

    rr_arb2 u_arb (
        .clk_i (Clk),
        .rst_i (Rst),
        .req_i ({DbgReq, IfReq}),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt)
    );

    // AW-bit add wraps modulo DEPTH
    assign beat_addr = base_q + AW'(cnt_q);

    assign IfData   = if_data_q;
    assign DbgRData = dbg_data_q;
    assign Busy     = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        dbg_data_d = dbg_data_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        MemAddr    = addr_q;
        MemWrData  = wr_q;
        MemWe      = 1'b0;
        IfValid    = 1'b0;
        DbgValid   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    owner_d = gnt[1] ? OWN_DBG : OWN_IF;
                    base_d  = gnt[1] ? DbgAddr[AW-1:0]
                                     : IfAddr[AW-1:0];
                    we_d    = gnt[1] & DbgWe;
                    wdata_d = gnt[1] ? DbgWData : wdata_q;
                    cnt_d   = 2'd0;
                    state_d = XFER;
                end
            end
            XFER: begin
                MemAddr = beat_addr;
                addr_d  = beat_addr;
                if (we_q) begin
                    MemWe     = 1'b1;
                    MemWrData = word_byte(wdata_q, cnt_q);
                    wr_d      = word_byte(wdata_q, cnt_q);
                end else if (owner_q == OWN_IF) begin
                    if_data_d[{cnt_q, 3'b000} +: 8] = MemRdData;
                end else begin
                    dbg_data_d[{cnt_q, 3'b000} +: 8] = MemRdData;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(BEATS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                IfValid  = (owner_q == OWN_IF);
                DbgValid = (owner_q == OWN_DBG);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            cnt_q      <= 2'd0;
            base_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            dbg_data_q <= '0;
            addr_q     <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_data_q  <= if_data_d;
            dbg_data_q <= dbg_data_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter with a transaction-level model.
// Drives directed and random fetch/debug traffic against a behavioural array.
module tb_imem_port_arbiter;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          IfReq, IfValid, DbgReq, DbgWe, DbgValid;
    logic [31:0]   IfAddr, IfData, DbgAddr, DbgWData, DbgRData;
    logic [AW-1:0] MemAddr;
    logic [7:0]    MemRdData, MemWrData;
    logic          MemWe, Busy;

    imem_port_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk(Clk), .Rst(Rst),
        .IfReq(IfReq), .IfAddr(IfAddr),
        .IfValid(IfValid), .IfData(IfData),
        .DbgReq(DbgReq), .DbgWe(DbgWe), .DbgAddr(DbgAddr),
        .DbgWData(DbgWData), .DbgValid(DbgValid), .DbgRData(DbgRData),
        .MemAddr(MemAddr), .MemRdData(MemRdData),
        .MemWe(MemWe), .MemWrData(MemWrData), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Behavioural memory array: combinational read, synchronous write
    logic [7:0]    mem [DEPTH];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [7:0]    pre_data;
    assign MemRdData = mem[MemAddr];
    always @(posedge Clk) begin
        if (MemWe) mem[MemAddr] <= MemWrData;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    // Requester state (index 0 = fetch, 1 = debug)
    logic [1:0]  reqv;
    logic [31:0] raddr [2];
    logic [31:0] rwdata [2];
    logic        rwe [2];
    bit          act [2];
    bit          granted [2];
    int          gcyc [2];
    assign IfReq    = reqv[0];
    assign DbgReq   = reqv[1];
    assign IfAddr   = raddr[0];
    assign DbgAddr  = raddr[1];
    assign DbgWe    = rwe[1];
    assign DbgWData = rwdata[1];

    // Reference model
    typedef struct { int own; logic [31:0] data; int cyc; } exp_t;
    typedef struct { int a; logic [7:0] b; int cyc; } wr_t;
    exp_t        exp_q [$];
    wr_t         wq [$];
    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] last_rd [2];
    int          free_cyc, last_gnt, cyc;
    int          p_new, p_drop;
    int          checks, errors;
    bit          scb_on;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic start(input int r, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        act[r]     = 1'b1;
        granted[r] = 1'b0;
        rwe[r]     = (r == 1) ? we : 1'b0;
        raddr[r]   = a;
        rwdata[r]  = d;
        reqv[r]    = 1'b1;
    endtask

    // Spec-level arbitration decision for the current cycle
    task automatic arbitrate();
        bit c0, c1;
        int w, base, a;
        logic [31:0] word;
        if (cyc < free_cyc) return;
        c0 = act[0] && !granted[0] && reqv[0];
        c1 = act[1] && !granted[1] && reqv[1];
        w = -1;
        if (c0 && c1) w = (last_gnt == 1) ? 0 : 1;
        else if (c0) w = 0;
        else if (c1) w = 1;
        if (w < 0) return;
        last_gnt   = w;
        granted[w] = 1'b1;
        gcyc[w]    = cyc;
        free_cyc   = cyc + 6;
        base = int'(raddr[w][AW-1:0]);
        if (rwe[w]) begin
            for (int i = 0; i < 4; i++) begin
                a = (base + i) % DEPTH;
                ref_mem[a] = rwdata[w][8*i +: 8];
                wq.push_back('{a, rwdata[w][8*i +: 8], cyc + 1 + i});
            end
        end else begin
            word = '0;
            for (int i = 0; i < 4; i++)
                word[8*i +: 8] = ref_mem[(base + i) % DEPTH];
            last_rd[w] = word;
        end
        exp_q.push_back('{w, last_rd[w], cyc + 5});
    endtask

    task automatic step();
        arbitrate();
        @(posedge Clk);
        #1;
        cyc++;
        for (int r = 0; r < 2; r++) begin
            if (act[r] && granted[r]) begin
                if (cyc == gcyc[r] + 6) begin
                    act[r]     = 1'b0;
                    granted[r] = 1'b0;
                    reqv[r]    = 1'b0;
                end else if (int'($urandom_range(99)) < p_drop) begin
                    reqv[r] = 1'b0;
                end
            end
            if (!act[r] && int'($urandom_range(99)) < p_new)
                start(r, 1'($urandom_range(1)), $urandom, $urandom);
        end
    endtask

    task automatic preload(input int a, input logic [7:0] b);
        pre_we     = 1'b1;
        pre_addr   = AW'(a);
        pre_data   = b;
        ref_mem[a] = b;
        step();
        pre_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((act[0] || act[1] || cyc < free_cyc) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) fail("wait_idle_timeout");
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_IfValid"},  32'(IfValid), 32'h0);
        chk({tag, "_DbgValid"}, 32'(DbgValid), 32'h0);
        chk({tag, "_MemWe"},    32'(MemWe), 32'h0);
        chk({tag, "_Busy"},     32'(Busy), 32'h0);
        chk({tag, "_IfData"},   IfData, 32'h0);
        chk({tag, "_DbgRData"}, DbgRData, 32'h0);
        chk({tag, "_MemAddr"},  32'(MemAddr), 32'h0);
        chk({tag, "_MemWrData"}, 32'(MemWrData), 32'h0);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues
    exp_t e;
    wr_t  w;
    always @(negedge Clk) begin
        if (scb_on) begin
            chk("busy", 32'(Busy),
                32'((cyc >= free_cyc - 5) && (cyc < free_cyc)));
            if (IfValid || DbgValid) begin
                if (IfValid && DbgValid) fail("both_valid");
                if (exp_q.size() == 0) begin
                    fail("unexpected_valid");
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_owner", 32'(DbgValid), 32'(e.own));
                    chk("valid_data", DbgValid ? DbgRData : IfData, e.data);
                    chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                fail("missing_valid");
            end
            if (MemWe) begin
                if (wq.size() == 0) begin
                    fail("unexpected_memwe");
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", 32'(MemAddr), 32'(w.a));
                    chk("wr_data", 32'(MemWrData), 32'(w.b));
                    chk("wr_cycle", 32'(cyc), 32'(w.cyc));
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                w = wq.pop_front();
                fail("missing_memwe");
            end
        end
    end

    initial begin
        checks = 0; errors = 0; scb_on = 1'b0;
        p_new = 0; p_drop = 0; free_cyc = 0; last_gnt = 1; cyc = 0;
        reqv = 2'b00; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int r = 0; r < 2; r++) begin
            raddr[r] = '0; rwdata[r] = '0; rwe[r] = 1'b0;
            act[r] = 1'b0; granted[r] = 1'b0; gcyc[r] = 0;
            last_rd[r] = '0;
        end
        Rst = 1'b0;
        #1 Rst = 1'b1;

        // Random initial contents, loaded while the DUT is held in reset
        for (int i = 0; i < DEPTH; i++) begin
            pre_we = 1'b1;
            pre_addr = AW'(i);
            pre_data = 8'($urandom);
            ref_mem[i] = pre_data;
            @(posedge Clk);
            #1;
        end
        pre_we = 1'b0;
        chk_outputs_zero("reset");
        Rst = 1'b0;
        cyc = 0;
        scb_on = 1'b1;

        // Contention from reset: If, Dbg, If
        start(0, 1'b0, $urandom, 32'h0);
        start(1, 1'($urandom_range(1)), $urandom, $urandom);
        p_new = 100;
        repeat (14) step();
        p_new = 0;
        wait_idle();

        // Fetch read at 0
        preload(0, 8'h13); preload(1, 8'h05);
        preload(2, 8'hA0); preload(3, 8'h00);
        start(0, 1'b0, 32'h0, 32'h0);
        wait_idle();
        chk("fetch_word", IfData, 32'h00A00513);

        // Wrapping fetch
        preload(62, 8'h11); preload(63, 8'h22);
        preload(0, 8'h33);  preload(1, 8'h44);
        start(0, 1'b0, 32'h3E, 32'h0);
        wait_idle();
        chk("wrap_word", IfData, 32'h44332211);

        // Debug write then fetch
        start(1, 1'b1, 32'h10, 32'hDEADBEEF);
        wait_idle();
        start(0, 1'b0, 32'h10, 32'h0);
        wait_idle();
        chk("write_fetch_word", IfData, 32'hDEADBEEF);

        // Fetch request dropped in cycle 2
        start(0, 1'b0, $urandom, 32'h0);
        step();
        step();
        reqv[0] = 1'b0;
        wait_idle();

        // Randomised mixed traffic
        p_new = 30;
        p_drop = 15;
        repeat (3000) step();
        p_new = 0;
        p_drop = 0;
        wait_idle();
        repeat (3) step();
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("wq_drained", 32'(wq.size()), 32'h0);

        // Reset during beat 2 of a debug write
        scb_on = 1'b0;
        preload(32, 8'hFF); preload(33, 8'hFF);
        preload(34, 8'hFF); preload(35, 8'hFF);
        raddr[1] = 32'h20;
        rwe[1] = 1'b1;
        rwdata[1] = 32'h11223344;
        reqv[1] = 1'b1;
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        Rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        @(negedge Clk);
        reqv[1] = 1'b0;
        @(posedge Clk);
        #1;
        chk_outputs_zero("midrst_hold");
        Rst = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            chk("midrst_no_dbgvalid", 32'(DbgValid), 32'h0);
        end
        chk("midrst_b0", 32'(mem[32]), 32'h44);
        chk("midrst_b1", 32'(mem[33]), 32'h33);
        chk("midrst_b2", 32'(mem[34]), 32'hFF);
        chk("midrst_b3", 32'(mem[35]), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequences and shares the byte-wide instruction memory port between two requesters: the core's instruction-fetch path and a debug/loader port used to read or patch program bytes. Each granted transaction moves one 32-bit little-endian word as four single-byte memory accesses. The block sits between the fetch stage and the 64-byte instruction memory array, which provides a combinational read port and a synchronous byte-write port.

## Interface
- `DEPTH`, 64: memory size in bytes; must be a power of two.
- `AW`, 6: byte address width, equal to log2(DEPTH).
- `Clk` in 1: the single clock; all state updates on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `IfReq` in 1: fetch request; held high until `IfValid`.
- `IfAddr` in 32: fetch byte address.
- `IfValid` out 1: one-cycle pulse when `IfData` holds the completed word.
- `IfData` out 32: assembled instruction word, little-endian.
- `DbgReq` in 1: debug request; held high until `DbgValid`.
- `DbgWe` in 1: 1 = write the word, 0 = read it.
- `DbgAddr` in 32: debug byte address.
- `DbgWData` in 32: write word; byte 0 is bits [7:0].
- `DbgValid` out 1: one-cycle completion pulse (both reads and writes).
- `DbgRData` out 32: assembled read word.
- `MemAddr` out AW: byte address driven to the array.
- `MemRdData` in 8: combinational read byte at `MemAddr`.
- `MemWe` out 1: byte write strobe, taken by the array at the rising edge.
- `MemWrData` out 8: write byte.
- `Busy` out 1: high while a transaction is in progress (XFER or DONE).

## Operation
- Three-state FSM:
  - IDLE: arbitrate and grant.
  - XFER: four byte beats.
  - DONE: completion pulse.
- Arbitration (IDLE only):
  - A single requester wins outright.
  - If both request, round-robin by a `LastGnt` flag: the requester not granted last wins.
  - On grant:
    - Latch owner, base address bits [AW-1:0], `DbgWe` and `DbgWData`.
    - Clear `ByteCnt`.
    - Update `LastGnt`.
    - Go to XFER.
- XFER:
  - `MemAddr` = (base + `ByteCnt`) mod DEPTH. Misaligned and wrapping words are legal; upper address bits are ignored.
  - Read: on each edge, capture `MemRdData` into byte lane `ByteCnt` of the owner's data register.
  - Write: `MemWe`=1 and `MemWrData` = latched word byte `ByteCnt`.
  - `ByteCnt` increments each cycle. After beat 3, go to DONE.
- DONE:
  - Pulse the owner's Valid for one cycle.
  - The data register holds its value until the owner's next transaction.
  - Return to IDLE.
- Requests are not re-sampled during XFER or DONE. A requester dropping Req mid-transaction does not abort it; Valid still pulses.
- A requester still high in the IDLE cycle after its Valid is treated as a new request.
- In IDLE, XFER-read and DONE, `MemWe`=0. `MemAddr` is held at the last value.
- Reset values:
  - State IDLE, `ByteCnt` 0.
  - `LastGnt` = Dbg, so fetch wins the first tie.
  - `IfValid`, `DbgValid`, `MemWe` and `Busy` all 0.
  - `IfData`, `DbgRData`, `MemAddr` and `MemWrData` all 0.
- Reset mid-transaction aborts immediately:
  - No Valid is issued.
  - Bytes already written stay written.

## Timing
- Request high in IDLE at cycle 0: grant registered at edge 0.
- Beats occur in cycles 1–4.
- Valid is high in cycle 5, so latency is 5 cycles.
- Back-to-back: the next grant is evaluated in cycle 6, giving one transaction per 6 cycles.
- Under continuous contention, grants alternate If, Dbg, If, Dbg, …
- `Busy` is high in cycles 1–5.
- The array's read is combinational, so captured data reflects any write from an earlier beat.

## Structure
- Package `imem_arb_pkg` holds:
  - The state enum (IDLE, XFER, DONE).
  - The owner enum (OWN_IF, OWN_DBG).
  - The `BEATS`=4 constant.
- One sub-module, `rr_arb2`: a two-requester round-robin arbiter.
  - Inputs: req[1:0], enable.
  - Outputs: one-hot grant.
  - Holds the `LastGnt` register.
- Byte lane steering, the counter and the FSM live in the top level.

## Test plan
- Fetch read: memory bytes 0x00..0x03 = 13,05,A0,00; `IfReq`=1, `IfAddr`=0 → `IfValid` pulses in cycle 5 with `IfData`=0x00A00513, and `Busy` is high in cycles 1–5.
- Wrap: `IfAddr`=0x3E with bytes [0x3E]=11, [0x3F]=22, [0x00]=33, [0x01]=44 → `IfData`=0x44332211.
- Debug write then fetch: `DbgWe`=1, `DbgAddr`=0x10, `DbgWData`=0xDEADBEEF.
  - Expect 4 `MemWe` pulses, at addresses 0x10..0x13 with bytes EF, BE, AD, DE.
  - `DbgValid` pulses in cycle 5.
  - A following fetch of 0x10 returns 0xDEADBEEF.
- Contention: `IfReq` and `DbgReq` held high from reset → grants go If, Dbg, If; Valid pulses in cycles 5, 11 and 17, alternating owners.
- Reset mid-op: assert `Rst` during beat 2 of a debug write → bytes 0 and 1 are written, byte 2 is not, no `DbgValid`, and all outputs are 0 while `Rst` is high.
- Dropped request: `IfReq` goes low in cycle 2 → `IfValid` still pulses in cycle 5, and no new grant follows.
